// File: rtl/switch_conditioner.sv
// Input conditioning for two pushbuttons and a 4-bit DIP bank: polarity fix,
// 2-flop synchronization, per-channel debounce, and registered event pulses.
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sw1_raw_i,
    input  logic       sw2_raw_i,
    input  logic [3:0] sw3_raw_i,
    output logic       sw1_o,
    output logic       sw2_o,
    output logic [3:0] sw3_o,
    output logic       sw1_press_o,
    output logic       sw2_press_o,
    output logic       sw3_chg_o
);

    localparam int NCH = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order: bit 0 = sw1, bit 1 = sw2, bits 5:2 = sw3[3:0]
    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   pol;
    logic [NCH-1:0]   s1;
    logic [NCH-1:0]   s2;
    logic [NCH-1:0]   q;
    logic [NCH-1:0]   flip;
    logic [CNT_W-1:0] cnt [NCH];
    logic             press1;
    logic             press2;
    logic             chg;

    assign raw = {sw3_raw_i, sw2_raw_i, sw1_raw_i};
    assign pol = ACTIVE_LOW ? ~raw : raw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pol;
            s2 <= s1;
        end
    end

    // A channel flips on the edge where its count has already reached the maximum
    always_comb begin
        flip = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            flip[i] = (s2[i] != q[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (s2[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    q[i]   <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            press1 <= 1'b0;
            press2 <= 1'b0;
            chg    <= 1'b0;
        end else begin
            press1 <= flip[0] & s2[0];
            press2 <= flip[1] & s2[1];
            chg    <= |flip[5:2];
        end
    end

    assign sw1_o       = q[0];
    assign sw2_o       = q[1];
    assign sw3_o       = q[5:2];
    assign sw1_press_o = press1;
    assign sw2_press_o = press2;
    assign sw3_chg_o   = chg;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: an active-low and an active-high instance share
// stimulus; a sliding-window debounce model predicts both every cycle.
module tb_switch_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw1_raw = 1'b1;
    logic       sw2_raw = 1'b1;
    logic [3:0] sw3_raw = 4'hF;

    logic       a_sw1, a_sw2, a_p1, a_p2, a_chg;
    logic [3:0] a_sw3;
    logic       b_sw1, b_sw2, b_p1, b_p2, b_chg;
    logic [3:0] b_sw3;

    logic [5:0] lv_a, lv_b;
    logic [2:0] pu_a, pu_b;
    assign lv_a = {a_sw3, a_sw2, a_sw1};
    assign lv_b = {b_sw3, b_sw2, b_sw1};
    assign pu_a = {a_chg, a_p2, a_p1};
    assign pu_b = {b_chg, b_p2, b_p1};

    int checks = 0;
    int failures = 0;

    // Model state: history of polarized samples {b, a}, levels and pulses per instance
    logic [11:0] hist [$];
    logic [5:0]  qm [2];
    logic [2:0]  pm [2];
    logic [5:0]  cur;

    always #5 clk = ~clk;

    switch_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .sw1_raw_i(sw1_raw), .sw2_raw_i(sw2_raw), .sw3_raw_i(sw3_raw),
        .sw1_o(a_sw1), .sw2_o(a_sw2), .sw3_o(a_sw3),
        .sw1_press_o(a_p1), .sw2_press_o(a_p2), .sw3_chg_o(a_chg)
    );

    switch_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .sw1_raw_i(sw1_raw), .sw2_raw_i(sw2_raw), .sw3_raw_i(sw3_raw),
        .sw1_o(b_sw1), .sw2_o(b_sw2), .sw3_o(b_sw3),
        .sw1_press_o(b_p1), .sw2_press_o(b_p2), .sw3_chg_o(b_chg)
    );

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back('0);
        qm[0] = '0; qm[1] = '0;
        pm[0] = '0; pm[1] = '0;
    endtask

    // A level flips once the last D synchronized samples (2 edges old) all disagree with it
    task automatic model_edge(input logic [5:0] r);
        int n;
        logic diff;
        logic [5:0] fl;
        logic [11:0] smp;
        if (rst) begin
            model_reset();
            return;
        end
        hist.push_back({r, ~r});
        n = hist.size();
        for (int p = 0; p < 2; p++) begin
            fl = '0;
            for (int ch = 0; ch < 6; ch++) begin
                diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    smp = hist[n - 3 - j];
                    if (smp[p * 6 + ch] == qm[p][ch]) diff = 1'b0;
                end
                fl[ch] = diff;
            end
            pm[p] = {|fl[5:2], fl[1] & ~qm[p][1], fl[0] & ~qm[p][0]};
            qm[p] = qm[p] ^ fl;
        end
        while (hist.size() > D + 3) void'(hist.pop_front());
    endtask

    task automatic step(input logic [5:0] r);
        sw1_raw = r[0];
        sw2_raw = r[1];
        sw3_raw = r[5:2];
        @(posedge clk);
        model_edge(r);
        #1;
        checks++;
        if (lv_a !== qm[0]) begin
            failures++;
            $display("FAIL level_a got=%h exp=%h t=%0t", lv_a, qm[0], $time);
        end
        checks++;
        if (lv_b !== qm[1]) begin
            failures++;
            $display("FAIL level_b got=%h exp=%h t=%0t", lv_b, qm[1], $time);
        end
        checks++;
        if (pu_a !== pm[0]) begin
            failures++;
            $display("FAIL pulse_a got=%b exp=%b t=%0t", pu_a, pm[0], $time);
        end
        checks++;
        if (pu_b !== pm[1]) begin
            failures++;
            $display("FAIL pulse_b got=%b exp=%b t=%0t", pu_b, pm[1], $time);
        end
    endtask

    task automatic test_reset();
        int bad;
        cur = '1;
        sw1_raw = 1'b1; sw2_raw = 1'b1; sw3_raw = 4'hF;
        rst = 1'b1;
        #2;
        checks++;
        if ({lv_a, pu_a, lv_b, pu_b} !== 18'd0) begin
            failures++;
            $display("FAIL reset_init got=%h exp=0", {lv_a, pu_a, lv_b, pu_b});
        end
        for (int i = 0; i < 3; i++) step(cur);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(cur);
        checks++;
        if (lv_b !== 6'h3F) begin
            failures++;
            $display("FAIL reset_pre_b got=%h exp=3f", lv_b);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({lv_b, pu_b, lv_a, pu_a} !== 18'd0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", {lv_b, pu_b, lv_a, pu_a});
        end
        model_reset();
        for (int i = 0; i < 2; i++) step(cur);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(cur);
            if ({lv_a, pu_a} !== 9'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_hold_a got=%0d nonzero cycles exp=0", bad);
        end
    endtask

    task automatic test_clean_press();
        int rise, fall, np, ppos, nr;
        cur = '1;
        for (int i = 0; i < 8; i++) step(cur);
        cur[0] = 1'b0;
        rise = 0; np = 0; ppos = 0;
        for (int k = 1; k <= 10; k++) begin
            step(cur);
            if (a_sw1 && rise == 0) rise = k;
            if (a_p1) begin np++; ppos = k; end
        end
        checks++;
        if (rise != 6) begin failures++; $display("FAIL press_latency got=%0d exp=6", rise); end
        checks++;
        if (np != 1 || ppos != 6) begin
            failures++;
            $display("FAIL press_pulse got=%0d@%0d exp=1@6", np, ppos);
        end
        cur[0] = 1'b1;
        fall = 0; nr = 0;
        for (int k = 1; k <= 10; k++) begin
            step(cur);
            if (!a_sw1 && fall == 0) fall = k;
            if (a_p1) nr++;
        end
        checks++;
        if (fall != 6) begin failures++; $display("FAIL release_latency got=%0d exp=6", fall); end
        checks++;
        if (nr != 0) begin failures++; $display("FAIL release_pulse got=%0d exp=0", nr); end
    endtask

    task automatic burst2();
        for (int i = 0; i < 3; i++) begin cur[1] = 1'b0; step(cur); end
        cur[1] = 1'b1; step(cur);
        for (int i = 0; i < 2; i++) begin cur[1] = 1'b0; step(cur); end
        cur[1] = 1'b1; step(cur);
    endtask

    task automatic test_bounce();
        int hi, rise, ppos;
        cur = '1;
        for (int i = 0; i < 8; i++) step(cur);
        burst2();
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            step(cur);
            if (a_sw2 || a_p2) hi++;
        end
        checks++;
        if (hi != 0 || a_sw2 !== 1'b0) begin
            failures++;
            $display("FAIL bounce_reject got=%0d exp=0", hi);
        end
        burst2();
        rise = 0; ppos = 0;
        cur[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(cur);
            if (a_sw2 && rise == 0) rise = k;
            if (a_p2) ppos = k;
        end
        checks++;
        if (rise != 6 || ppos != 6) begin
            failures++;
            $display("FAIL bounce_then_hold got=%0d/%0d exp=6/6", rise, ppos);
        end
        cur[1] = 1'b1;
        for (int i = 0; i < 8; i++) step(cur);
    endtask

    task automatic test_dip();
        int k6, nchg;
        logic [3:0] val;
        cur = '1;
        for (int i = 0; i < 8; i++) step(cur);
        cur[5:2] = 4'hA;
        k6 = 0; nchg = 0; val = 4'h0;
        for (int k = 1; k <= 10; k++) begin
            step(cur);
            if (a_sw3 != 4'h0 && k6 == 0) begin k6 = k; val = a_sw3; end
            if (a_chg) nchg++;
        end
        checks++;
        if (k6 != 6 || val !== 4'h5) begin
            failures++;
            $display("FAIL dip_level got=%h@%0d exp=5@6", val, k6);
        end
        checks++;
        if (nchg != 1) begin failures++; $display("FAIL dip_chg got=%0d exp=1", nchg); end
        cur[5:2] = 4'hF;
        for (int i = 0; i < 10; i++) step(cur);
    endtask

    task automatic test_reset_midcount();
        int rise, np;
        cur = '1;
        for (int i = 0; i < 8; i++) step(cur);
        cur[0] = 1'b0;
        for (int i = 0; i < 4; i++) step(cur);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_sw1 !== 1'b0 || a_p1 !== 1'b0) begin
            failures++;
            $display("FAIL midcount_reset got=%b%b exp=00", a_sw1, a_p1);
        end
        model_reset();
        step(cur);
        rst = 1'b0;
        rise = 0; np = 0;
        for (int k = 1; k <= 10; k++) begin
            step(cur);
            if (a_sw1 && rise == 0) rise = k;
            if (a_p1) np++;
        end
        checks++;
        if (rise != 6 || np != 1) begin
            failures++;
            $display("FAIL midcount_release got=%0d/%0d exp=6/1", rise, np);
        end
        cur = '1;
        for (int i = 0; i < 8; i++) step(cur);
    endtask

    task automatic test_active_high();
        int both, n1, n2;
        cur = '0;
        for (int i = 0; i < 8; i++) step(cur);
        cur[1:0] = 2'b11;
        both = 0; n1 = 0; n2 = 0;
        for (int k = 1; k <= 10; k++) begin
            step(cur);
            if (b_p1 && b_p2 && both == 0) both = k;
            if (b_p1) n1++;
            if (b_p2) n2++;
        end
        checks++;
        if (both != 6 || n1 != 1 || n2 != 1) begin
            failures++;
            $display("FAIL active_high_pair got=%0d/%0d/%0d exp=6/1/1", both, n1, n2);
        end
        checks++;
        if (b_sw1 !== 1'b1 || b_sw2 !== 1'b1) begin
            failures++;
            $display("FAIL active_high_level got=%b%b exp=11", b_sw2, b_sw1);
        end
    endtask

    task automatic test_random();
        cur = 6'($urandom);
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
            end
            step(cur);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_dip();
        test_reset_midcount();
        test_active_high();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
